// File: rtl/dskw_mem_arb.sv
// -----------------------------------------------------------------------------
// dskw_mem_arb
//   Arbitrates a single-port image RAM (1-cycle read latency) between three
//   requesters: host load/unload (H), deskew pixel read (R) and deskew pixel
//   write (W). At most one access is granted per cycle. The host has priority;
//   R and W share the remaining slots round-robin. Read data is returned to
//   the requester that issued the read, two cycles after its grant.
//
// Configuration macro:
//   DSKW_ARB_STARVE_GUARD_EN - when defined, after MAX_WAIT consecutive host
//                              grants with a deskew port waiting, the next slot
//                              is forced to the deskew side. Undefined: strict
//                              host priority.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   h_req/h_we/h_addr/h_wdata     host request; h_gnt accept, h_rvld read valid
//   r_req/r_addr                  deskew read request; r_gnt accept, r_rvld valid
//   w_req/w_addr/w_wdata          deskew write request; w_gnt accept
//   rdata                         shared read data, qualified by h_rvld/r_rvld
//   mem_en/mem_we/mem_addr/mem_wdata  registered RAM command
//   mem_rdata                     RAM read data, valid 1 cycle after a read
//   addr_err                      pulse: granted request addressed >= MEM_DEPTH
// -----------------------------------------------------------------------------
module dskw_mem_arb #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 131072,
    parameter int MAX_WAIT   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  h_req,
    input  logic                  h_we,
    input  logic [ADDR_WIDTH-1:0] h_addr,
    input  logic [DATA_WIDTH-1:0] h_wdata,
    output logic                  h_gnt,
    output logic                  h_rvld,
    input  logic                  r_req,
    input  logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  r_gnt,
    output logic                  r_rvld,
    input  logic                  w_req,
    input  logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0] w_wdata,
    output logic                  w_gnt,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  addr_err
);

    typedef enum logic {PTR_R, PTR_W} rr_t;
    typedef enum logic {OWN_H, OWN_R} own_t;

    // One extra bit so MEM_DEPTH == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(MEM_DEPTH);

    rr_t                   rr_ptr;
    logic                  starve_hit;
    logic                  dsk_ok;
    logic                  any_gnt;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    own_t                  sel_own;
    logic                  addr_bad;

    // Read tag pipeline: stage 1 aligns with the RAM command, stage 2 with
    // the RAM read data. err marks out-of-range reads that return zero.
    logic tag1_vld, tag1_err;
    own_t tag1_own;
    logic tag2_vld, tag2_err;
    own_t tag2_own;

`ifdef DSKW_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    logic [CNT_W-1:0] starve_cnt;

    assign starve_hit = (starve_cnt == CNT_W'(MAX_WAIT)) && (r_req || w_req);
`else
    // Guard disabled: the host is never overridden. MAX_WAIT is kept in the
    // parameter list so both builds share one interface.
    assign starve_hit = (MAX_WAIT < 0);
`endif

    always_comb begin
        dsk_ok = !h_req || starve_hit;
        h_gnt  = h_req && !starve_hit;
        r_gnt  = dsk_ok && r_req && (!w_req || rr_ptr == PTR_R);
        w_gnt  = dsk_ok && w_req && (!r_req || rr_ptr == PTR_W);
        any_gnt = h_gnt || r_gnt || w_gnt;

        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_own   = OWN_H;
        if (h_gnt) begin
            sel_we    = h_we;
            sel_addr  = h_addr;
            sel_wdata = h_we ? h_wdata : '0;
            sel_own   = OWN_H;
        end else if (r_gnt) begin
            sel_addr  = r_addr;
            sel_own   = OWN_R;
        end else if (w_gnt) begin
            sel_we    = 1'b1;
            sel_addr  = w_addr;
            sel_wdata = w_wdata;
        end
        addr_bad = {1'b0, sel_addr} >= DEPTH_L;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= PTR_R;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            addr_err  <= 1'b0;
            tag1_vld  <= 1'b0;
            tag1_err  <= 1'b0;
            tag1_own  <= OWN_H;
            tag2_vld  <= 1'b0;
            tag2_err  <= 1'b0;
            tag2_own  <= OWN_H;
`ifdef DSKW_ARB_STARVE_GUARD_EN
            starve_cnt <= '0;
`endif
        end else begin
            if (r_gnt)
                rr_ptr <= PTR_W;
            else if (w_gnt)
                rr_ptr <= PTR_R;

            // Out-of-range accesses are acknowledged but never reach the RAM.
            mem_en    <= any_gnt && !addr_bad;
            mem_we    <= any_gnt && !addr_bad && sel_we;
            mem_addr  <= (any_gnt && !addr_bad) ? sel_addr : '0;
            mem_wdata <= (any_gnt && !addr_bad) ? sel_wdata : '0;
            addr_err  <= any_gnt && addr_bad;

            tag1_vld  <= any_gnt && !sel_we;
            tag1_err  <= addr_bad;
            tag1_own  <= sel_own;
            tag2_vld  <= tag1_vld;
            tag2_err  <= tag1_err;
            tag2_own  <= tag1_own;

`ifdef DSKW_ARB_STARVE_GUARD_EN
            if (r_gnt || w_gnt)
                starve_cnt <= '0;
            else if (h_gnt && (r_req || w_req) && starve_cnt != CNT_W'(MAX_WAIT))
                starve_cnt <= starve_cnt + 1'b1;
`endif
        end
    end

    // RAM data arrives in the stage-2 cycle; it is passed straight through so
    // the read latency stays at two cycles.
    assign h_rvld = tag2_vld && (tag2_own == OWN_H);
    assign r_rvld = tag2_vld && (tag2_own == OWN_R);
    assign rdata  = (tag2_vld && !tag2_err) ? mem_rdata : '0;

endmodule

// File: tb/tb_dskw_mem_arb.sv
module tb_dskw_mem_arb;

    localparam int AW = 17;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          h_req, h_we;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_wdata;
    logic          h_gnt, h_rvld;
    logic          r_req;
    logic [AW-1:0] r_addr;
    logic          r_gnt, r_rvld;
    logic          w_req;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;
    logic          w_gnt;
    logic [DW-1:0] rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          addr_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] ram [0:1023];

    always #5 clk = ~clk;

    dskw_mem_arb #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MEM_DEPTH (1000),
        .MAX_WAIT  (8)
    ) dut (
        .clk(clk), .rst(rst),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rvld(h_rvld),
        .r_req(r_req), .r_addr(r_addr), .r_gnt(r_gnt), .r_rvld(r_rvld),
        .w_req(w_req), .w_addr(w_addr), .w_wdata(w_wdata), .w_gnt(w_gnt),
        .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .addr_err(addr_err)
    );

    // Single-port RAM model, 1-cycle read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we)
                ram[mem_addr[9:0]] <= mem_wdata;
            else
                mem_rdata <= ram[mem_addr[9:0]];
        end
    end

    // Advance to the next cycle; inputs are driven 1 ns after the edge and
    // outputs sampled 3 ns later, well before the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        h_req = 0; h_we = 0; h_addr = '0; h_wdata = '0;
        r_req = 0; r_addr = '0;
        w_req = 0; w_addr = '0; w_wdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        logic [63:0] outs;
        do_reset();
        #3;
        outs = {h_gnt, r_gnt, w_gnt, h_rvld, r_rvld, rdata, mem_en, mem_we,
                mem_addr, mem_wdata, addr_err};
        n_cmp++;
        if (outs !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
    endtask

    task automatic test_host_wr_rd();
        // cycle t: host write 0x2A @0x10
        h_req = 1; h_we = 1; h_addr = 17'h00010; h_wdata = 8'h2A;
        #3;
        n_cmp++;
        if ({h_gnt, r_gnt, w_gnt} !== 3'b100) begin
            n_bad++;
            $display("FAIL hw_gnt: got %b expected 100", {h_gnt, r_gnt, w_gnt});
        end
        tick();
        // cycle t+1: write on the RAM bus; present host read back-to-back
        h_we = 0; h_wdata = '0;
        #3;
        n_cmp++;
        if ({mem_en, mem_we, mem_addr, mem_wdata, addr_err} !== {1'b1, 1'b1, 17'h00010, 8'h2A, 1'b0}) begin
            n_bad++;
            $display("FAIL hw_mem_cmd: got en=%b we=%b a=%h d=%h err=%b expected en=1 we=1 a=00010 d=2a err=0",
                     mem_en, mem_we, mem_addr, mem_wdata, addr_err);
        end
        n_cmp++;
        if (h_gnt !== 1'b1) begin
            n_bad++;
            $display("FAIL hr_gnt: got %b expected 1", h_gnt);
        end
        tick();
        h_req = 0;
        #3;
        n_cmp++;
        if ({mem_en, mem_we, mem_addr, h_rvld} !== {1'b1, 1'b0, 17'h00010, 1'b0}) begin
            n_bad++;
            $display("FAIL hr_mem_cmd: got en=%b we=%b a=%h rvld=%b expected en=1 we=0 a=00010 rvld=0",
                     mem_en, mem_we, mem_addr, h_rvld);
        end
        tick();
        #3;
        n_cmp++;
        if ({h_rvld, r_rvld, rdata} !== {1'b1, 1'b0, 8'h2A}) begin
            n_bad++;
            $display("FAIL hr_rdata: got h_rvld=%b r_rvld=%b rdata=%h expected 1 0 2a",
                     h_rvld, r_rvld, rdata);
        end
        tick();
        #3;
        n_cmp++;
        if (h_rvld !== 1'b0) begin
            n_bad++;
            $display("FAIL hr_rvld_pulse: got %b expected 0", h_rvld);
        end
    endtask

    task automatic test_rr_alternate();
        do_reset();
        r_req = 1; r_addr = 17'h00020;
        w_req = 1; w_addr = 17'h00030; w_wdata = 8'h77;
        for (int c = 0; c < 6; c++) begin
            #3;
            n_cmp++;
            if ({r_gnt, w_gnt, h_gnt} !== {(c % 2 == 0), (c % 2 == 1), 1'b0}) begin
                n_bad++;
                $display("FAIL rr_cycle%0d: got r=%b w=%b h=%b expected r=%b w=%b h=0",
                         c, r_gnt, w_gnt, h_gnt, (c % 2 == 0), (c % 2 == 1));
            end
            tick();
        end
        idle_inputs();
        tick();
        tick();
        // A lone deskew writer is granted every cycle.
        w_req = 1; w_addr = 17'h00031; w_wdata = 8'h11;
        for (int c = 0; c < 2; c++) begin
            #3;
            n_cmp++;
            if (w_gnt !== 1'b1) begin
                n_bad++;
                $display("FAIL lone_w%0d: got %b expected 1", c, w_gnt);
            end
            tick();
        end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_host_priority();
        int ncyc;
        logic er, ew, eh;
        do_reset();
        h_req = 1; h_we = 0; h_addr = 17'h00005;
        r_req = 1; r_addr = 17'h00006;
        w_req = 1; w_addr = 17'h00030; w_wdata = 8'h33;
`ifdef DSKW_ARB_STARVE_GUARD_EN
        ncyc = 19;
`else
        ncyc = 10;
`endif
        for (int c = 0; c < ncyc; c++) begin
`ifdef DSKW_ARB_STARVE_GUARD_EN
            er = (c == 8);
            ew = (c == 17);
`else
            er = 1'b0;
            ew = 1'b0;
`endif
            eh = !er && !ew;
            #3;
            n_cmp++;
            if ({h_gnt, r_gnt, w_gnt} !== {eh, er, ew}) begin
                n_bad++;
                $display("FAIL prio_cycle%0d: got h=%b r=%b w=%b expected h=%b r=%b w=%b",
                         c, h_gnt, r_gnt, w_gnt, eh, er, ew);
            end
            tick();
        end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_addr_err();
        do_reset();
        // Last valid word: normal access.
        r_req = 1; r_addr = 17'd999;
        tick();
        r_addr = 17'd1000;
        #3;
        n_cmp++;
        if ({mem_en, addr_err, mem_addr} !== {1'b1, 1'b0, 17'd999}) begin
            n_bad++;
            $display("FAIL addr_999: got en=%b err=%b a=%0d expected en=1 err=0 a=999",
                     mem_en, addr_err, mem_addr);
        end
        n_cmp++;
        if (r_gnt !== 1'b1) begin
            n_bad++;
            $display("FAIL addr_1000_gnt: got %b expected 1", r_gnt);
        end
        tick();
        r_req = 0;
        #3;
        n_cmp++;
        if ({mem_en, addr_err} !== 2'b01) begin
            n_bad++;
            $display("FAIL addr_1000_cmd: got en=%b err=%b expected en=0 err=1", mem_en, addr_err);
        end
        tick();
        #3;
        n_cmp++;
        if ({r_rvld, rdata, addr_err} !== {1'b1, 8'h00, 1'b0}) begin
            n_bad++;
            $display("FAIL addr_1000_rd: got rvld=%b rdata=%h err=%b expected rvld=1 rdata=00 err=0",
                     r_rvld, rdata, addr_err);
        end
        tick();
        // Out-of-range write: flagged, no RAM access, no read-valid.
        w_req = 1; w_addr = 17'd1500; w_wdata = 8'hEE;
        tick();
        w_req = 0;
        #3;
        n_cmp++;
        if ({mem_en, addr_err} !== 2'b01) begin
            n_bad++;
            $display("FAIL addr_wr_cmd: got en=%b err=%b expected en=0 err=1", mem_en, addr_err);
        end
        tick();
        #3;
        n_cmp++;
        if ({h_rvld, r_rvld} !== 2'b00) begin
            n_bad++;
            $display("FAIL addr_wr_rvld: got %b expected 00", {h_rvld, r_rvld});
        end
        tick();
    endtask

    task automatic test_reset_midflight();
        logic [63:0] outs;
        idle_inputs();
        h_req = 1; h_we = 0; h_addr = 17'h00001;
        #3;
        n_cmp++;
        if (h_gnt !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_gnt: got %b expected 1", h_gnt);
        end
        tick();
        h_req = 0;
        rst = 1;
        #3;
        n_cmp++;
        if ({mem_en, mem_we} !== 2'b10) begin
            n_bad++;
            $display("FAIL mid_cmd: got en=%b we=%b expected en=1 we=0", mem_en, mem_we);
        end
        tick();
        rst = 0;
        #3;
        outs = {h_gnt, r_gnt, w_gnt, h_rvld, r_rvld, rdata, mem_en, mem_we,
                mem_addr, mem_wdata, addr_err};
        n_cmp++;
        if (outs !== '0) begin
            n_bad++;
            $display("FAIL mid_after_rst: got %h expected 0", outs);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            r_req = (c < 4);
            r_addr = (c < 4) ? AW'(c) : '0;
            #3;
            if (c < 4) begin
                n_cmp++;
                if (r_gnt !== 1'b1) begin
                    n_bad++;
                    $display("FAIL b2b_gnt%0d: got %b expected 1", c, r_gnt);
                end
            end
            if (c >= 1 && c <= 4) begin
                n_cmp++;
                if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, AW'(c - 1)}) begin
                    n_bad++;
                    $display("FAIL b2b_addr%0d: got en=%b we=%b a=%0d expected en=1 we=0 a=%0d",
                             c, mem_en, mem_we, mem_addr, c - 1);
                end
            end
            if (c >= 2 && c <= 5) begin
                exp_d = 8'(c - 2) ^ 8'h5A;
                n_cmp++;
                if ({r_rvld, h_rvld, rdata} !== {1'b1, 1'b0, exp_d}) begin
                    n_bad++;
                    $display("FAIL b2b_rd%0d: got r_rvld=%b h_rvld=%b rdata=%h expected 1 0 %h",
                             c, r_rvld, h_rvld, rdata, exp_d);
                end
            end
            if (c == 6) begin
                n_cmp++;
                if (r_rvld !== 1'b0) begin
                    n_bad++;
                    $display("FAIL b2b_end: got r_rvld=%b expected 0", r_rvld);
                end
            end
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++)
            ram[i] = 8'(i) ^ 8'h5A;
        mem_rdata = '0;
        rst = 1;
        idle_inputs();
        test_reset();
        test_host_wr_rd();
        test_rr_alternate();
        test_host_priority();
        test_addr_err();
        test_reset_midflight();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
